// File: rtl/prescaled_timer_arbiter_pkg.sv
// Shared definitions for the prescaled timer arbiter: FSM state encoding and
// default geometry (requester count, prescaler period, counter widths).
package prescaled_timer_arbiter_pkg;

   localparam int NREQ_DEF     = 4;
   localparam int PRESCALE_DEF = 100;
   localparam int PSW_DEF      = 7;
   localparam int TW_DEF       = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/prescaled_timer_arbiter_prescaler_tick.sv
// Enabled divide-by-PRESCALE counter with synchronous clear and a registered
// tick that is high while the count sits at PRESCALE-1. Falling-edge clocked.
module prescaler_tick
   import prescaled_timer_arbiter_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_DEF,
   parameter int PSW      = PSW_DEF
)(
   input  logic           CLK,
   input  logic           CLEAR,
   input  logic           EN,
   input  logic           SCLR,
   output logic           TICK,
   output logic [PSW-1:0] Count
);

   logic [PSW-1:0] r_count;
   logic           r_tick;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its inputs from before the edge.
   always_ff @(negedge CLK or negedge CLEAR) begin
      if (!CLEAR) begin
         r_count <= '0;
         r_tick  <= 1'b0;
      end else if (SCLR) begin
         r_count <= '0;
         r_tick  <= 1'b0;
      end else if (EN) begin
         r_count <= (r_count == PSW'(PRESCALE - 1)) ? '0 : r_count + PSW'(1);
         r_tick  <= (r_count == PSW'(PRESCALE - 2));
      end else begin
         r_tick  <= 1'b0;
      end
   end

   assign Count = r_count;
   assign TICK  = r_tick;

endmodule

// File: rtl/prescaled_timer_arbiter.sv
// Round-robin shared countdown timer: grants one requester at a time, counts
// LOAD prescaler periods, then pulses DONE to the owner. Falling-edge clocked.
module prescaled_timer_arbiter
   import prescaled_timer_arbiter_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int PRESCALE = PRESCALE_DEF,
   parameter int PSW      = PSW_DEF,
   parameter int TW       = TW_DEF
)(
   input  logic               CLK,
   input  logic               CLEAR,
   input  logic [NREQ-1:0]    REQ,
   input  logic [NREQ*TW-1:0] LOAD,
   output logic [NREQ-1:0]    GNT,
   output logic [NREQ-1:0]    DONE,
   output logic               BUSY,
   output logic               TICK,
   output logic [TW-1:0]      Remaining
);

   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          r_state, w_state_nxt;
   logic [NREQ-1:0] r_gnt, w_gnt_nxt;
   logic [NREQ-1:0] r_done, w_done_nxt;
   logic [OW-1:0]   r_owner, w_owner_nxt;
   logic [OW-1:0]   r_rr, w_rr_nxt;
   logic [OW-1:0]   w_pick, w_owner_inc;
   logic [TW-1:0]   r_remaining, w_remaining_nxt;
   logic            w_found, w_en, w_sclr, w_tick;
   logic [PSW-1:0]  w_count;

   prescaler_tick #(
      .PRESCALE (PRESCALE),
      .PSW      (PSW)
   ) u_prescaler (
      .CLK   (CLK),
      .CLEAR (CLEAR),
      .EN    (w_en),
      .SCLR  (w_sclr),
      .TICK  (w_tick),
      .Count (w_count)
   );

   // First pending requester at or after the rr pointer, wrapping upward.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && REQ[(int'(r_rr) + k) % NREQ]) begin
            w_found = 1'b1;
            w_pick  = OW'((int'(r_rr) + k) % NREQ);
         end
      end
   end

   assign w_owner_inc = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_gnt_nxt       = r_gnt;
      w_done_nxt      = '0;
      w_owner_nxt     = r_owner;
      w_rr_nxt        = r_rr;
      w_remaining_nxt = r_remaining;
      w_en            = 1'b0;
      w_sclr          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt         = ST_RUN;
               w_owner_nxt         = w_pick;
               w_gnt_nxt           = '0;
               w_gnt_nxt[w_pick]   = 1'b1;
               w_remaining_nxt     = LOAD[int'(w_pick)*TW +: TW];
               w_sclr              = 1'b1;
            end
         end
         ST_RUN: begin
            if (!REQ[r_owner]) begin
               // Abort wins over a completion landing on the same edge.
               w_state_nxt     = ST_IDLE;
               w_gnt_nxt       = '0;
               w_remaining_nxt = '0;
               w_rr_nxt        = w_owner_inc;
               w_sclr          = 1'b1;
            end else if (r_remaining == '0) begin
               w_done_nxt[r_owner] = 1'b1;
               w_state_nxt         = ST_FINISH;
            end else begin
               w_en = 1'b1;
               if (w_count == PSW'(PRESCALE - 1)) begin
                  w_remaining_nxt = r_remaining - TW'(1);
                  if (r_remaining == TW'(1)) begin
                     w_done_nxt[r_owner] = 1'b1;
                     w_state_nxt         = ST_FINISH;
                  end
               end
            end
         end
         ST_FINISH: begin
            w_gnt_nxt   = '0;
            w_rr_nxt    = w_owner_inc;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(negedge CLK or negedge CLEAR) begin
      if (!CLEAR) begin
         r_state     <= ST_IDLE;
         r_gnt       <= '0;
         r_done      <= '0;
         r_owner     <= '0;
         r_rr        <= '0;
         r_remaining <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt       <= w_gnt_nxt;
         r_done      <= w_done_nxt;
         r_owner     <= w_owner_nxt;
         r_rr        <= w_rr_nxt;
         r_remaining <= w_remaining_nxt;
      end
   end

   assign GNT       = r_gnt;
   assign DONE      = r_done;
   assign BUSY      = (r_state != ST_IDLE);
   assign TICK      = w_tick;
   assign Remaining = r_remaining;

endmodule

// File: tb/tb_prescaled_timer_arbiter.sv
// Directed bench for prescaled_timer_arbiter with PRESCALE=4. State changes on
// falling edges; the bench drives and samples on rising edges.
module tb_prescaled_timer_arbiter;

   localparam int NREQ     = 4;
   localparam int PRESCALE = 4;
   localparam int PSW      = 3;
   localparam int TW       = 8;

   logic               CLK;
   logic               CLEAR;
   logic [NREQ-1:0]    REQ;
   logic [NREQ*TW-1:0] LOAD;
   logic [NREQ-1:0]    GNT;
   logic [NREQ-1:0]    DONE;
   logic               BUSY;
   logic               TICK;
   logic [TW-1:0]      Remaining;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   prescaled_timer_arbiter #(
      .NREQ     (NREQ),
      .PRESCALE (PRESCALE),
      .PSW      (PSW),
      .TW       (TW)
   ) dut (
      .CLK       (CLK),
      .CLEAR     (CLEAR),
      .REQ       (REQ),
      .LOAD      (LOAD),
      .GNT       (GNT),
      .DONE      (DONE),
      .BUSY      (BUSY),
      .TICK      (TICK),
      .Remaining (Remaining)
   );

   initial CLK = 1'b1;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Advance n rising edges; each one follows exactly one active falling edge.
   task automatic adv(input int n);
      repeat (n) @(posedge CLK);
      cyc += n;
   endtask

   task automatic do_reset();
      @(posedge CLK);
      REQ   = '0;
      CLEAR = 1'b0;
      @(posedge CLK);
      CLEAR = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " gnt"},  32'(GNT),       32'h0);
      check({tag, " done"}, 32'(DONE),      32'h0);
      check({tag, " busy"}, 32'(BUSY),      32'h0);
      check({tag, " tick"}, 32'(TICK),      32'h0);
      check({tag, " rem"},  32'(Remaining), 32'h0);
   endtask

   // Single-grant LOAD=3 trace, indexed by edges after E0. TICK is registered on
   // the PS-2 -> PS-1 edge, so it is high in the cycles ending at E0+4/8/12.
   int t1_rem  [14] = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
   int t1_tick [14] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
   int t1_done [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
   int t1_gnt  [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

   initial begin
      logic seen_done;
      CLEAR = 1'b1;
      REQ   = '0;
      LOAD  = '0;
      #2 CLEAR = 1'b0;
      #1 check_all_zero("reset");
      @(posedge CLK);
      CLEAR = 1'b1;

      // 1: single requester, LOAD=3
      LOAD[0*TW +: TW] = 8'd3;
      REQ = 4'b0001;
      @(posedge CLK); cyc = 0;
      for (int c = 0; c < 14; c++) begin
         check($sformatf("t1 gnt c%0d", c),  32'(GNT),       32'(t1_gnt[c]));
         check($sformatf("t1 rem c%0d", c),  32'(Remaining), 32'(t1_rem[c]));
         check($sformatf("t1 tick c%0d", c), 32'(TICK),      32'(t1_tick[c]));
         check($sformatf("t1 done c%0d", c), 32'(DONE),      32'(t1_done[c]));
         check($sformatf("t1 busy c%0d", c), 32'(BUSY),      32'(c <= 12));
         if (c == 12) REQ = '0;
         adv(1);
      end

      // 2: REQ=0101, LOAD0=1, LOAD2=2, round-robin alternation
      do_reset();
      LOAD[0*TW +: TW] = 8'd1;
      LOAD[2*TW +: TW] = 8'd2;
      REQ = 4'b0101;
      @(posedge CLK); cyc = 0;
      check("t2 gnt0 c0", 32'(GNT), 32'h1);
      adv(4);  check("t2 done0 c4", 32'(DONE), 32'h1);
      adv(1);  check("t2 gap gnt c5", 32'(GNT), 32'h0);
               check("t2 gap busy c5", 32'(BUSY), 32'h0);
      adv(1);  check("t2 gnt2 c6", 32'(GNT), 32'h4);
               check("t2 rem c6", 32'(Remaining), 32'd2);
      adv(7);  check("t2 no done c13", 32'(DONE), 32'h0);
      adv(1);  check("t2 done2 c14", 32'(DONE), 32'h4);
               check("t2 rem c14", 32'(Remaining), 32'd0);
      adv(2);  check("t2 gnt0 again c16", 32'(GNT), 32'h1);
      REQ = '0;

      // 3: all four requesting with LOAD=1; 6-cycle grant period
      do_reset();
      LOAD = {8'd1, 8'd1, 8'd1, 8'd1};
      REQ  = 4'b1111;
      @(posedge CLK); cyc = 0;
      for (int c = 0; c < 29; c++) begin
         if (c % 6 == 0)
            check($sformatf("t3 gnt c%0d", c), 32'(GNT), 32'(1 << ((c / 6) % 4)));
         if (c % 6 == 4)
            check($sformatf("t3 done c%0d", c), 32'(DONE), 32'(1 << ((c / 6) % 4)));
         if (c % 6 == 5) begin
            check($sformatf("t3 gap gnt c%0d", c), 32'(GNT), 32'h0);
            check($sformatf("t3 gap busy c%0d", c), 32'(BUSY), 32'h0);
         end
         adv(1);
      end
      REQ = '0;

      // 4: LOAD=0 completes on the first RUN edge without prescaling
      do_reset();
      LOAD = '0;
      REQ  = 4'b0010;
      @(posedge CLK); cyc = 0;
      check("t4 gnt c0", 32'(GNT), 32'h2);
      check("t4 rem c0", 32'(Remaining), 32'd0);
      adv(1);  check("t4 done c1", 32'(DONE), 32'h2);
               check("t4 tick c1", 32'(TICK), 32'h0);
      REQ = '0;
      adv(1);  check("t4 busy c2", 32'(BUSY), 32'h0);
               check("t4 done c2", 32'(DONE), 32'h0);

      // 5: owner 0 aborts at E0+5; requester 1 served next
      do_reset();
      LOAD = '0;
      LOAD[0*TW +: TW] = 8'd3;
      LOAD[1*TW +: TW] = 8'd1;
      REQ = 4'b0011;
      seen_done = 1'b0;
      @(posedge CLK); cyc = 0;
      check("t5 gnt0 c0", 32'(GNT), 32'h1);
      for (int c = 0; c < 4; c++) begin
         seen_done |= |DONE;
         adv(1);
      end
      check("t5 rem c4", 32'(Remaining), 32'd2);
      REQ[0] = 1'b0;
      adv(1);
      seen_done |= |DONE;
      check("t5 abort gnt c5", 32'(GNT), 32'h0);
      check("t5 abort busy c5", 32'(BUSY), 32'h0);
      check("t5 abort rem c5", 32'(Remaining), 32'd0);
      check("t5 no done", 32'(seen_done), 32'h0);
      adv(1);  check("t5 gnt1 c6", 32'(GNT), 32'h2);
      adv(4);  check("t5 done1 c10", 32'(DONE), 32'h2);
      REQ = '0;

      // 6: CLEAR mid-RUN resets outputs and the rr pointer
      do_reset();
      LOAD = '0;
      REQ  = 4'b0001;
      @(posedge CLK); cyc = 0;
      check("t6 gnt0 c0", 32'(GNT), 32'h1);
      adv(1);  check("t6 done0 c1", 32'(DONE), 32'h1);
      REQ = 4'b0100;
      LOAD[2*TW +: TW] = 8'd3;
      adv(2);  check("t6 gnt2 c3", 32'(GNT), 32'h4);
      adv(2);
      CLEAR = 1'b0;
      #1 check_all_zero("t6 clear");
      LOAD[0*TW +: TW] = 8'd2;
      REQ = 4'b0101;
      @(posedge CLK);
      CLEAR = 1'b1;
      @(posedge CLK);
      check("t6 post-clear gnt", 32'(GNT), 32'h1);
      check("t6 post-clear rem", 32'(Remaining), 32'd2);
      REQ = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/prescaled_timer_arbiter.md
Name: prescaled_timer_arbiter

Overview:
- Shares one prescaled countdown timer between NREQ requesters.
- Each requester asks for a timeout of LOAD prescaler periods.
- A round-robin arbiter grants the timer to one requester at a time. The controller sequences the prescaler and countdown, then returns a one-cycle DONE pulse to the owner.
- Sits between the divide-by-N event counters and the control FSMs that need timed waits.

Parameters:
- NREQ, 4, number of requesters.
- PRESCALE, 100, prescaler period in CLK cycles (≥2).
- PSW, 7, prescaler count width; must satisfy 2^PSW ≥ PRESCALE.
- TW, 8, timeout count width.

Ports:
- CLK  input  1  clock; all state updates on the falling edge.
- CLEAR  input  1  asynchronous active-low reset.
- REQ  input  NREQ  per-requester request level; held until DONE, or dropped to abort.
- LOAD  input  NREQ*TW  per-requester timeout in prescaler periods; slice i = LOAD[i*TW +: TW].
- GNT  output  NREQ  registered one-hot grant; all zero when idle.
- DONE  output  NREQ  registered one-cycle completion pulse to the owner.
- BUSY  output  1  high whenever the state is not IDLE.
- TICK  output  1  registered prescaler tick, one cycle per PRESCALE cycles while running.
- Remaining  output  TW  current countdown value.

Behaviour:
- Reset (CLEAR=0, asynchronous): state=IDLE, GNT=0, DONE=0, BUSY=0, TICK=0, Remaining=0, prescaler count=0, rr pointer=0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - If any REQ is high, pick the first requester at or after the rr pointer (searching upward with wrap).
  - At edge E0: GNT<=onehot(owner), Remaining<=LOAD[owner], prescaler cleared to 0, state<=RUN.
  - No REQ: stay in IDLE.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - TICK<=1 on the edge where the count goes from PRESCALE-2 to PRESCALE-1. This is the same registered timing as the existing divide-by-N counter.
  - Remaining decrements by 1 on each edge where the count wraps from PRESCALE-1 to 0.
  - At the wrap edge where Remaining is 1: Remaining<=0, DONE[owner]<=1, state<=FINISH.
  - Result: DONE is asserted at edge E0 + K*PRESCALE for LOAD=K≥1.
- LOAD=0: RUN exits at edge E0+1 with DONE[owner]<=1 and no prescaling.
- FINISH (one cycle):
  - DONE<=0, GNT<=0, rr pointer<=(owner+1) mod NREQ, state<=IDLE.
  - The earliest next grant is at the following edge, so there is a minimum one-cycle IDLE gap.
- Abort:
  - If REQ[owner] is low at any RUN edge: state<=IDLE, GNT<=0, no DONE, prescaler cleared, Remaining<=0, rr pointer<=owner+1.
  - Abort takes priority over completion on the same edge.
- Requests from non-owners while BUSY are ignored; no queueing beyond the REQ levels.
- REQ is sampled level-sensitive. A requester whose REQ is still high in IDLE after its own DONE is granted again only after other pending requesters, because the rr pointer has advanced past it.
- LOAD is sampled only at grant. Changes to it during RUN have no effect.
- CLEAR asserted mid-RUN: all outputs return to reset values immediately, and no DONE is produced.
- Invariants: GNT is always one-hot or zero; at most one DONE bit is high; DONE is only asserted together with the matching GNT bit.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_FINISH) and the default PRESCALE/PSW/TW values.
- Sub-module prescaler_tick, instantiated once:
  - Ports: CLK, CLEAR, EN, SCLR, TICK, Count.
  - Behaviour: enabled divide-by-PRESCALE counter with synchronous clear and registered tick.
- The arbiter, FSM and countdown stay in the top module.

Test Plan:
- PRESCALE=4, REQ=0001, LOAD0=3 → GNT=0001 at E0; TICK high at E0+4, E0+8 and E0+12; DONE=0001 at E0+12 for one cycle; GNT=0 at E0+13; Remaining reads 3,2,1,0.
- PRESCALE=4, REQ=0101 held, LOAD0=1, LOAD2=2 → first grant to 0 (DONE at E0+4); next grant to 2 at E0+6 (DONE at E0+14); next grant back to 0.
- REQ=1111 held from reset with LOAD=1 each → grants 0,1,2,3,0 in order; each grant lasts PRESCALE+1 cycles, with a one-cycle gap between grants.
- LOAD1=0, REQ=0010 → GNT=0010 at E0; DONE=0010 at E0+1; BUSY low at E0+2.
- Owner drops REQ at E0+5 with LOAD=3 → GNT=0 and BUSY=0 after that edge; DONE never asserts; the next pending requester is granted at the following edge.
- CLEAR pulsed low mid-RUN → all outputs 0 asynchronously; after release, the rr pointer is 0 and requester 0 is served first if pending.
